display_scan_ctrl: RTL and testbench

Time-multiplexing controller for the dual seven-segment display. It generates the `select` that steers the shared 7-bit segment bus between the two digit patterns, and the active-low anode enables that light one digit at a time. A blanking interval with both anodes off is inserted around every select change so the previous digit's pattern never ghosts onto the next digit. It sits between the segment-pattern selection path and the anode driver transistors.

---
 rtl/display_pkg.sv | 35 +++
 rtl/display_scan_ctrl.sv | 66 ++++++
 tb/tb_display_scan_ctrl.sv | 115 +++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared types and constants for the seven-segment scan path.
package display_pkg;

  typedef enum logic [1:0] {BLANK0, SHOW0, BLANK1, SHOW1} scan_state_t;

  localparam logic [1:0] AN_OFF  = 2'b11;
  localparam logic [1:0] AN_DIG0 = 2'b10;
  localparam logic [1:0] AN_DIG1 = 2'b01;

  // 2 kHz per digit and a 10 us blank at a 48 MHz core clock
  localparam int DEF_DIV_CYCLES   = 24000;
  localparam int DEF_BLANK_CYCLES = 480;

  function automatic scan_state_t scan_succ(input scan_state_t s);
    case (s)
      BLANK0:  scan_succ = SHOW0;
      SHOW0:   scan_succ = BLANK1;
      BLANK1:  scan_succ = SHOW1;
      default: scan_succ = BLANK0;
    endcase
  endfunction

  function automatic logic [1:0] scan_an(input scan_state_t s);
    case (s)
      SHOW0:   scan_an = AN_DIG0;
      SHOW1:   scan_an = AN_DIG1;
      default: scan_an = AN_OFF;
    endcase
  endfunction

  function automatic logic scan_select(input scan_state_t s);
    scan_select = (s == BLANK1) || (s == SHOW1);
  endfunction

endpackage

// File: rtl/display_scan_ctrl.sv
// Dual-digit scan FSM: select leads each anode turn-on by a full blank dwell.
// Outputs are registered from the next state, so they move on the same edge as the FSM.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int DIV_CYCLES   = DEF_DIV_CYCLES,
  parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  output logic       select,
  output logic [1:0] an,
  output logic       frame
);

  localparam int MAX_N = (DIV_CYCLES > BLANK_CYCLES) ? DIV_CYCLES : BLANK_CYCLES;
  localparam int CW    = (MAX_N > 1) ? $clog2(MAX_N) : 1;

  localparam logic [CW-1:0] DIV_LAST   = CW'(DIV_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  if (DIV_CYCLES < 1) begin : g_bad_div
    $error("display_scan_ctrl: DIV_CYCLES must be >= 1");
  end
  if (BLANK_CYCLES < 1) begin : g_bad_blank
    $error("display_scan_ctrl: BLANK_CYCLES must be >= 1");
  end

  scan_state_t   state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt, dwell_last;
  logic          frame_nxt;

  always_comb begin
    dwell_last = ((state == SHOW0) || (state == SHOW1)) ? DIV_LAST : BLANK_LAST;
    state_nxt  = state;
    cnt_nxt    = cnt + 1'b1;
    frame_nxt  = 1'b0;
    if (!enable) begin
      state_nxt = BLANK0;
      cnt_nxt   = '0;
    end else if (cnt == dwell_last) begin
      state_nxt = scan_succ(state);
      cnt_nxt   = '0;
      // only a completed scan pulses frame; restarts from reset/disable do not
      frame_nxt = (state == SHOW1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= BLANK0;
      cnt    <= '0;
      select <= 1'b0;
      an     <= AN_OFF;
      frame  <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      select <= scan_select(state_nxt);
      an     <= scan_an(state_nxt);
      frame  <= frame_nxt;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl: nominal (4/2) and minimum-dwell (1/1) instances.
module tb_display_scan_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_a, enable_a, select_a, frame_a;
  logic [1:0] an_a;
  logic       reset_m, enable_m, select_m, frame_m;
  logic [1:0] an_m;

  int checks = 0;
  int errors = 0;

  display_scan_ctrl #(.DIV_CYCLES(4), .BLANK_CYCLES(2)) u_dut (
    .clk(clk), .reset(reset_a), .enable(enable_a),
    .select(select_a), .an(an_a), .frame(frame_a)
  );

  display_scan_ctrl #(.DIV_CYCLES(1), .BLANK_CYCLES(1)) u_min (
    .clk(clk), .reset(reset_m), .enable(enable_m),
    .select(select_m), .an(an_m), .frame(frame_m)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Hand-written 12-cycle scan table for DIV=4, BLANK=2
  function automatic logic [1:0] exp_an(input int p);
    case (p)
      0, 1, 6, 7:    exp_an = 2'b11;
      2, 3, 4, 5:    exp_an = 2'b10;
      default:       exp_an = 2'b01;
    endcase
  endfunction

  // idx counts cycles from the first BLANK0 cycle of a fresh start
  task automatic step_scan(input string tag, input int idx);
    @(negedge clk);
    check({tag, "_an"},  {6'd0, an_a}, {6'd0, exp_an(idx % 12)});
    check({tag, "_sel"}, {7'd0, select_a}, {7'd0, ((idx % 12) >= 6) ? 1'b1 : 1'b0});
    check({tag, "_frm"}, {7'd0, frame_a}, {7'd0, ((idx % 12) == 0 && idx != 0) ? 1'b1 : 1'b0});
  endtask

  task automatic check_off(input string tag);
    check({tag, "_an"},  {6'd0, an_a}, 8'h03);
    check({tag, "_sel"}, {7'd0, select_a}, 8'h00);
    check({tag, "_frm"}, {7'd0, frame_a}, 8'h00);
  endtask

  initial begin
    logic       prev_sel;
    logic [1:0] exp_an_m [4];
    logic       exp_sel_m [4];
    exp_an_m[0] = 2'b11; exp_an_m[1] = 2'b10; exp_an_m[2] = 2'b11; exp_an_m[3] = 2'b01;
    exp_sel_m[0] = 1'b0; exp_sel_m[1] = 1'b0; exp_sel_m[2] = 1'b1; exp_sel_m[3] = 1'b1;

    reset_a = 1'b1; enable_a = 1'b1;
    reset_m = 1'b1; enable_m = 1'b1;

    // 1. reset held for 3 cycles; third sample is also the first BLANK0 cycle
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_off("rst");
    end
    reset_a = 1'b0;

    // 2. steady scan, ending on the second SHOW1 cycle (idx 45)
    for (int i = 1; i <= 45; i++) step_scan("scan", i);

    // 4. mid-dwell disable in SHOW1
    enable_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_off("dis");
    end
    enable_a = 1'b1;
    for (int i = 1; i <= 3; i++) step_scan("reen", i);

    // 5. one-cycle reset while in SHOW0 (idx 3)
    reset_a = 1'b1;
    @(negedge clk);
    check_off("mrst");
    reset_a = 1'b0;
    for (int i = 1; i <= 13; i++) step_scan("rscan", i);

    // 3. random enable toggling: an never 00, select moves only while blanked
    prev_sel = select_a;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 7) == 0) enable_a = ~enable_a;
      @(negedge clk);
      check("inv_an00", {7'd0, (an_a == 2'b00)}, 8'h00);
      check("inv_sel", {7'd0, ((select_a != prev_sel) && (an_a != 2'b11))}, 8'h00);
      prev_sel = select_a;
    end

    // 6. minimum dwell instance, held in reset until now
    check("min_rst_an", {6'd0, an_m}, 8'h03);
    check("min_rst_frm", {7'd0, frame_m}, 8'h00);
    reset_m = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      check("min_an", {6'd0, an_m}, {6'd0, exp_an_m[i % 4]});
      check("min_sel", {7'd0, select_m}, {7'd0, exp_sel_m[i % 4]});
      check("min_frm", {7'd0, frame_m}, {7'd0, ((i % 4) == 0) ? 1'b1 : 1'b0});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
